// File: rtl/spi_pwm_gen.sv
// PWM generator fed by the SPI register bank; shadow registers reload only at period wrap.
// Optional complementary dead-time output enabled by defining SPI_PWM_DEADTIME_EN.
module spi_pwm_gen #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned DEAD    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         ctrl_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [WIDTH-1:0]   period_i,
  input  logic [WIDTH-1:0]   duty_i,
  output logic               pwm_o,
  output logic               pwm_n_o,
  output logic               period_tick_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] pre;
  logic [PRESC_W-1:0] presc_sh;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   period_sh;
  logic [WIDTH-1:0]   duty_sh;
  logic               pol_sh;
  logic               oneshot_sh;

  logic en;
  logic tick;
  logic wrap;
  logic raw;
  logic pol_eff;

  // Bits [7:3] of ctrl carry nothing for this block.
  logic unused_ok;
  assign unused_ok = &{1'b0, ctrl_i[7:3], (DEAD != 0)};

  always_comb begin
    en      = ctrl_i[0];
    tick    = (state == S_RUN) && (pre == presc_sh);
    wrap    = tick && (cnt == period_sh);
    raw     = (state == S_RUN) && (cnt < duty_sh);
    // Inactive level follows the live input until a period is actually running.
    pol_eff = (state == S_RUN) ? pol_sh : ctrl_i[1];
  end

  // Control FSM, prescaler, period counter and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pre           <= '0;
      cnt           <= '0;
      presc_sh      <= '0;
      period_sh     <= '0;
      duty_sh       <= '0;
      pol_sh        <= 1'b0;
      oneshot_sh    <= 1'b0;
      period_tick_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      period_tick_o <= 1'b0;
      case (state)
        S_IDLE: begin
          pre    <= '0;
          cnt    <= '0;
          busy_o <= en;
          if (en) state <= S_LOAD;
        end
        S_LOAD: begin
          presc_sh   <= presc_i;
          period_sh  <= period_i;
          duty_sh    <= duty_i;
          pol_sh     <= ctrl_i[1];
          oneshot_sh <= ctrl_i[2];
          pre        <= '0;
          cnt        <= '0;
          busy_o     <= 1'b1;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (!en) begin
            pre    <= '0;
            cnt    <= '0;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else if (tick) begin
            pre <= '0;
            if (wrap) begin
              cnt           <= '0;
              period_tick_o <= 1'b1;
              presc_sh      <= presc_i;
              period_sh     <= period_i;
              duty_sh       <= duty_i;
              pol_sh        <= ctrl_i[1];
              oneshot_sh    <= ctrl_i[2];
              if (oneshot_sh) begin
                busy_o <= 1'b0;
                state  <= S_IDLE;
              end else begin
                busy_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end else begin
            pre <= pre + PRESC_W'(1);
          end
        end
        default: begin
          pre    <= '0;
          cnt    <= '0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_PWM_DEADTIME_EN
  localparam int unsigned DW = 4;

  logic [DW-1:0] dc_a;
  logic [DW-1:0] dc_b;
  logic          raw_n;
  logic          act_a;
  logic          act_b;

  // A channel goes active only once its request has been held for DEAD cycles.
  always_comb begin
    raw_n = (state == S_RUN) && !raw;
    act_a = raw && (dc_a >= DW'(DEAD));
    act_b = raw_n && (dc_b >= DW'(DEAD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_a    <= '0;
      dc_b    <= '0;
      pwm_o   <= 1'b0;
      pwm_n_o <= 1'b0;
    end else begin
      if (!raw) dc_a <= '0;
      else if (dc_a < DW'(DEAD)) dc_a <= dc_a + DW'(1);
      if (!raw_n) dc_b <= '0;
      else if (dc_b < DW'(DEAD)) dc_b <= dc_b + DW'(1);
      pwm_o   <= act_a ^ pol_eff;
      pwm_n_o <= act_b ^ pol_eff;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_o <= 1'b0;
    else        pwm_o <= raw ^ pol_eff;
  end

  assign pwm_n_o = 1'b0;
`endif

endmodule
